axi_lite_reg_slave: RTL and testbench

//  AXI4-Lite responder (slave) exposing a word-addressed register bank to an AXI-Lite master.

---
 rtl/axi_lite_reg_slave.sv | 207 ++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: RW control words below RO_BASE, RO status words from ro_in above it.
// Write and read channels are independent, each with one transaction outstanding.
module axi_lite_reg_slave #(
  parameter int C_S_AXI_LITE_ADDR_WIDTH = 32,
  parameter int C_S_AXI_LITE_DATA_WIDTH = 32,
  parameter int NUM_REGS                = 16,
  parameter int RO_BASE                 = 8
) (
  input  logic                                          s_axi_lite_aclk,
  input  logic                                          s_axi_lite_arstn,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]            s_axi_lite_awaddr,
  input  logic                                          s_axi_lite_awvalid,
  output logic                                          s_axi_lite_awready,
  input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0]            s_axi_lite_wdata,
  input  logic [C_S_AXI_LITE_DATA_WIDTH/8-1:0]          s_axi_lite_wstrb,
  input  logic                                          s_axi_lite_wvalid,
  output logic                                          s_axi_lite_wready,
  output logic [1:0]                                    s_axi_lite_bresp,
  output logic                                          s_axi_lite_bvalid,
  input  logic                                          s_axi_lite_bready,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]            s_axi_lite_araddr,
  input  logic                                          s_axi_lite_arvalid,
  output logic                                          s_axi_lite_arready,
  output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]            s_axi_lite_rdata,
  output logic [1:0]                                    s_axi_lite_rresp,
  output logic                                          s_axi_lite_rvalid,
  input  logic                                          s_axi_lite_rready,
  output logic [RO_BASE*C_S_AXI_LITE_DATA_WIDTH-1:0]    reg_out,
  output logic [RO_BASE-1:0]                            reg_wr_pulse,
  input  logic [(NUM_REGS-RO_BASE)*C_S_AXI_LITE_DATA_WIDTH-1:0] ro_in
);

  localparam int AW    = C_S_AXI_LITE_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_LITE_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [AW-1:0] NUM_REGS_A = AW'(NUM_REGS);
  localparam logic [AW-1:0] RO_BASE_A  = AW'(RO_BASE);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [DW-1:0] rw_regs   [RO_BASE];
  logic [DW-1:0] all_words [NUM_REGS];

  logic          aw_hold;
  logic          w_hold;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;

  logic             aw_fire;
  logic             w_fire;
  logic             aw_have;
  logic             w_have;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [SW-1:0]    wr_strb;
  logic [AW-1:0]    wr_word;
  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;

  logic [AW-1:0]    rd_word;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_idx;

  logic unused_addr_bits;

  assign aw_fire = s_axi_lite_awvalid && s_axi_lite_awready;
  assign w_fire  = s_axi_lite_wvalid && s_axi_lite_wready;
  assign aw_have = aw_hold || aw_fire;
  assign w_have  = w_hold || w_fire;

  // A held beat and a same-cycle handshake never coexist, so the hold selects the source.
  assign wr_addr = aw_hold ? aw_addr_q : s_axi_lite_awaddr;
  assign wr_data = w_hold  ? w_data_q  : s_axi_lite_wdata;
  assign wr_strb = w_hold  ? w_strb_q  : s_axi_lite_wstrb;
  assign wr_word = {2'b00, wr_addr[AW-1:2]};
  assign wr_ok   = wr_word < RO_BASE_A;
  assign wr_idx  = wr_word[IDX_W-1:0];

  assign rd_word     = {2'b00, s_axi_lite_araddr[AW-1:2]};
  assign rd_in_range = rd_word < NUM_REGS_A;
  assign rd_idx      = rd_word[IDX_W-1:0];

  assign unused_addr_bits = ^{wr_addr[1:0], s_axi_lite_araddr[1:0]};

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_words
      if (g < RO_BASE) begin : g_rw
        assign all_words[g]       = rw_regs[g];
        assign reg_out[g*DW +: DW] = rw_regs[g];
      end else begin : g_ro
        assign all_words[g] = ro_in[(g-RO_BASE)*DW +: DW];
      end
    end
  endgenerate

  always_ff @(posedge s_axi_lite_aclk) begin
    if (!s_axi_lite_arstn) begin
      wr_state           <= WR_IDLE;
      s_axi_lite_awready <= 1'b0;
      s_axi_lite_wready  <= 1'b0;
      s_axi_lite_bvalid  <= 1'b0;
      s_axi_lite_bresp   <= RESP_OKAY;
      aw_hold            <= 1'b0;
      w_hold             <= 1'b0;
      aw_addr_q          <= '0;
      w_data_q           <= '0;
      w_strb_q           <= '0;
      reg_wr_pulse       <= '0;
      for (int i = 0; i < RO_BASE; i++) rw_regs[i] <= '0;
    end else begin
      reg_wr_pulse <= '0;
      case (wr_state)
        WR_IDLE: begin
          if (aw_have && w_have) begin
            if (wr_ok) begin
              for (int i = 0; i < RO_BASE; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                  for (int b = 0; b < SW; b++) begin
                    if (wr_strb[b]) rw_regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                  end
                  reg_wr_pulse[i] <= 1'b1;
                end
              end
            end
            s_axi_lite_bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_lite_bvalid  <= 1'b1;
            s_axi_lite_awready <= 1'b0;
            s_axi_lite_wready  <= 1'b0;
            aw_hold            <= 1'b0;
            w_hold             <= 1'b0;
            wr_state           <= WR_RESP;
          end else begin
            if (aw_fire) begin
              aw_hold   <= 1'b1;
              aw_addr_q <= s_axi_lite_awaddr;
            end
            if (w_fire) begin
              w_hold   <= 1'b1;
              w_data_q <= s_axi_lite_wdata;
              w_strb_q <= s_axi_lite_wstrb;
            end
            s_axi_lite_awready <= !aw_have;
            s_axi_lite_wready  <= !w_have;
          end
        end
        WR_RESP: begin
          if (s_axi_lite_bready) begin
            s_axi_lite_bvalid  <= 1'b0;
            s_axi_lite_awready <= 1'b1;
            s_axi_lite_wready  <= 1'b1;
            wr_state           <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read data is taken from the pre-edge register view, so a read handshaking on the
  // commit edge of a write to the same register returns the old value.
  always_ff @(posedge s_axi_lite_aclk) begin
    if (!s_axi_lite_arstn) begin
      rd_state           <= RD_IDLE;
      s_axi_lite_arready <= 1'b0;
      s_axi_lite_rvalid  <= 1'b0;
      s_axi_lite_rdata   <= '0;
      s_axi_lite_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (s_axi_lite_arvalid && s_axi_lite_arready) begin
            s_axi_lite_arready <= 1'b0;
            s_axi_lite_rvalid  <= 1'b1;
            rd_state           <= RD_DATA;
            if (rd_in_range) begin
              s_axi_lite_rdata <= all_words[rd_idx];
              s_axi_lite_rresp <= RESP_OKAY;
            end else begin
              s_axi_lite_rdata <= '0;
              s_axi_lite_rresp <= RESP_SLVERR;
            end
          end else begin
            s_axi_lite_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s_axi_lite_rready) begin
            s_axi_lite_rvalid  <= 1'b0;
            s_axi_lite_arready <= 1'b1;
            rd_state           <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed and randomized bench for axi_lite_reg_slave against a register-bank reference model.
// All driving and sampling happens on the falling clock edge.
module tb_axi_lite_reg_slave;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int RB  = 8;
  localparam int NRO = NR - RB;

  logic              clk = 1'b0;
  logic              arstn = 1'b0;
  logic [AW-1:0]     awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [DW-1:0]     wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [AW-1:0]     araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [RB*DW-1:0]  reg_out;
  logic [RB-1:0]     reg_wr_pulse;
  logic [NRO*DW-1:0] ro_in = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] model_rw [RB];

  always #5 clk = ~clk;

  axi_lite_reg_slave #(
    .C_S_AXI_LITE_ADDR_WIDTH(AW),
    .C_S_AXI_LITE_DATA_WIDTH(DW),
    .NUM_REGS(NR),
    .RO_BASE(RB)
  ) dut (
    .s_axi_lite_aclk(clk),
    .s_axi_lite_arstn(arstn),
    .s_axi_lite_awaddr(awaddr),
    .s_axi_lite_awvalid(awvalid),
    .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata),
    .s_axi_lite_wstrb(wstrb),
    .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready),
    .s_axi_lite_bresp(bresp),
    .s_axi_lite_bvalid(bvalid),
    .s_axi_lite_bready(bready),
    .s_axi_lite_araddr(araddr),
    .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata),
    .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid),
    .s_axi_lite_rready(rready),
    .reg_out(reg_out),
    .reg_wr_pulse(reg_wr_pulse),
    .ro_in(ro_in)
  );

  // Single comparison point: every check in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [RB*DW-1:0] obs, input logic [RB*DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RB*DW-1:0] modelRegOut();
    logic [RB*DW-1:0] v;
    for (int i = 0; i < RB; i++) v[i*DW +: DW] = model_rw[i];
    return v;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < RB; i++) model_rw[i] = '0;
  endtask

  // Register-bank semantics: word index below RB is writable, anything else is refused.
  task automatic modelWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [RB-1:0] pulse);
    longint unsigned word;
    word  = longint'(addr) >> 2;
    pulse = '0;
    if (word < RB) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model_rw[word][8*b +: 8] = data[8*b +: 8];
      pulse[word] = 1'b1;
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic modelRead(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
    longint unsigned word;
    word = longint'(addr) >> 2;
    if (word < RB) begin
      data = model_rw[word];
      resp = 2'b00;
    end else if (word < NR) begin
      data = ro_in[(word - RB)*DW +: DW];
      resp = 2'b00;
    end else begin
      data = '0;
      resp = 2'b10;
    end
  endtask

  // Write transaction driver; delays are in cycles from the start of the transaction.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                               input int aw_delay, input int w_delay, input int b_delay,
                               output logic [1:0] resp, output int lat, output logic [RB-1:0] pulse_or,
                               output int pulse_cycles, output logic proto_ok, output logic done);
    bit aw_done, w_done, b_seen, hs_aw, hs_w, hs_b;
    int c_done;
    aw_done = 0; w_done = 0; b_seen = 0; c_done = -1;
    awaddr = addr; wdata = data; wstrb = strb;
    resp = 2'b11; lat = -1; pulse_or = '0; pulse_cycles = 0; proto_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      awvalid = !aw_done && (c >= aw_delay);
      wvalid  = !w_done && (c >= w_delay);
      bready  = (c >= b_delay);
      if (aw_done && awready) proto_ok = 1'b0;
      if (w_done && wready) proto_ok = 1'b0;
      if (b_seen && (!bvalid || bresp !== resp)) proto_ok = 1'b0;
      if (bvalid && !b_seen) begin
        b_seen = 1;
        resp   = bresp;
        lat    = c - c_done;
      end
      if (reg_wr_pulse != '0) begin
        pulse_or |= reg_wr_pulse;
        pulse_cycles++;
      end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      @(negedge clk);
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      if ((hs_aw || hs_w) && aw_done && w_done) c_done = c;
      if (hs_b) done = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic applyReadStimulus(input logic [AW-1:0] addr, input int ar_delay, input int r_delay,
                                   output logic [DW-1:0] data, output logic [1:0] resp, output int lat,
                                   output logic proto_ok, output logic done);
    bit ar_done, r_seen, hs_ar, hs_r;
    int c_hs;
    ar_done = 0; r_seen = 0; c_hs = -1;
    araddr = addr;
    data = 'x; resp = 2'b11; lat = -1; proto_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      arvalid = !ar_done && (c >= ar_delay);
      rready  = (c >= r_delay);
      if (ar_done && arready) proto_ok = 1'b0;
      if (r_seen && (!rvalid || rdata !== data || rresp !== resp)) proto_ok = 1'b0;
      if (rvalid && !r_seen) begin
        r_seen = 1;
        data   = rdata;
        resp   = rresp;
        lat    = c - c_hs;
      end
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      @(negedge clk);
      if (hs_ar) begin
        ar_done = 1;
        c_hs    = c;
      end
      if (hs_r) done = 1'b1;
    end
    arvalid = 1'b0; rready = 1'b0;
  endtask

  // Write through the driver and compare every observable against the model.
  task automatic doWrite(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [3:0] strb, input int awd, input int wd, input int bd);
    logic [1:0] resp, exp_resp;
    logic [RB-1:0] pulse_or, exp_pulse;
    int lat, pcyc;
    logic proto_ok, done;
    applyStimulus(addr, data, strb, awd, wd, bd, resp, lat, pulse_or, pcyc, proto_ok, done);
    modelWrite(addr, data, strb, exp_resp, exp_pulse);
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".bresp"}, resp, exp_resp);
    checkOutput({tag, ".latency"}, lat, 1);
    checkOutput({tag, ".pulse"}, pulse_or, exp_pulse);
    checkOutput({tag, ".pulse_cycles"}, pcyc, (exp_pulse != '0) ? 1 : 0);
    checkOutput({tag, ".protocol"}, proto_ok, 1);
    checkOutput({tag, ".reg_out"}, reg_out, modelRegOut());
  endtask

  task automatic doRead(input string tag, input logic [AW-1:0] addr, input int ard, input int rd);
    logic [DW-1:0] data, exp_data;
    logic [1:0] resp, exp_resp;
    int lat;
    logic proto_ok, done;
    modelRead(addr, exp_data, exp_resp);
    applyReadStimulus(addr, ard, rd, data, resp, lat, proto_ok, done);
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".rdata"}, data, exp_data);
    checkOutput({tag, ".rresp"}, resp, exp_resp);
    checkOutput({tag, ".latency"}, lat, 1);
    checkOutput({tag, ".protocol"}, proto_ok, 1);
  endtask

  initial begin
    logic [AW-1:0] addr;
    logic [DW-1:0] pre_val;
    logic [1:0]    dummy_resp;
    logic [RB-1:0] dummy_pulse;

    modelClear();
    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("reset.bvalid", bvalid, 0);
    checkOutput("reset.rvalid", rvalid, 0);
    checkOutput("reset.readies", {awready, wready, arready}, 3'b000);
    checkOutput("reset.reg_out", reg_out, '0);
    checkOutput("reset.pulse", reg_wr_pulse, '0);
    checkOutput("reset.rdata", rdata, '0);
    checkOutput("reset.resps", {bresp, rresp}, 4'b0000);
    arstn = 1'b1;
    @(negedge clk);
    checkOutput("release.readies", {awready, wready, arready}, 3'b111);

    $display("[TB] aligned AW/W write");
    doWrite("t1", 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    checkOutput("t1.reg1", reg_out[1*DW +: DW], 32'hDEADBEEF);

    $display("[TB] W ahead of AW, stalled B");
    doWrite("t2", 32'h0C, 32'h0BADF00D, 4'hF, 3, 0, 9);

    $display("[TB] byte strobes");
    doWrite("t3a", 32'h08, 32'h11223344, 4'hF, 0, 0, 0);
    doWrite("t3b", 32'h08, 32'hAABBCCDD, 4'h5, 1, 0, 0);
    checkOutput("t3.reg2", reg_out[2*DW +: DW], 32'h11BB33DD);

    $display("[TB] RO read with stalled R");
    ro_in[0 +: DW] = 32'h0000CAFE;
    doRead("t4", 32'h20, 0, 5);

    $display("[TB] RO and out-of-range accesses");
    doWrite("t5a", 32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    doWrite("t5b", 32'h40, 32'h12345678, 4'hF, 0, 0, 0);
    doRead("t5c", 32'h40, 0, 0);
    doRead("t5d", 32'h1000_0004, 0, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NRO; i++) ro_in[i*DW +: DW] = $urandom();
      addr = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) addr = addr | (32'h100 << $urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1)
        doWrite("rnd.wr", addr, $urandom(), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6));
      else
        doRead("rnd.rd", addr, $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("[TB] simultaneous read/write then reset with responses pending");
    pre_val = model_rw[3];
    awaddr = 32'h0C; wdata = 32'h5A5A1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 32'h0C; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    modelWrite(32'h0C, 32'h5A5A1234, 4'hF, dummy_resp, dummy_pulse);
    checkOutput("t6.both_valid", {bvalid, rvalid}, 2'b11);
    checkOutput("t6.read_precommit", rdata, pre_val);
    checkOutput("t6.reg3", reg_out[3*DW +: DW], 32'h5A5A1234);
    arstn = 1'b0;
    @(negedge clk);
    checkOutput("t6.valids_after_reset", {bvalid, rvalid}, 2'b00);
    checkOutput("t6.reg_out_after_reset", reg_out, '0);
    arstn = 1'b1;
    modelClear();
    @(negedge clk);
    doWrite("t6.after", 32'h18, 32'hC0FFEE01, 4'hF, 0, 1, 2);
    doRead("t6.readback", 32'h18, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
